// File: rtl/interp_tx_pkg.sv
// Shared types and helpers for the interpreter stream transmitter.
// The WAIT_ACK state exists only when INTERP_TX_ACK_EN is defined.
package interp_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW
`ifdef INTERP_TX_ACK_EN
    , WAIT_ACK
`endif
  } tx_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_OUT_W  = 8;
  localparam int DEF_DEPTH  = 8;

  localparam int CHUNKS = DEF_DATA_W / DEF_OUT_W;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int LVL_W  = $clog2(DEF_DEPTH) + 1;

  // Chunk slot (counted from the LSB end) that is transmitted first.
  function automatic int chunk_sel(input int chunks, input bit lsb_first);
    return lsb_first ? 0 : chunks - 1;
  endfunction

endpackage

// File: rtl/interp_fifo.sv
// Synchronous FIFO with occupancy count. A push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module interp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/interp_stream_tx.sv
// Captures CPU load data while COM is active and serialises it to the
// interpreter in OUT_W-bit chunks. Define INTERP_TX_ACK_EN for ack pacing.
module interp_stream_tx
  import interp_tx_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int STROBE_HI = 2,
  parameter int STROBE_LO = 2,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   com_en,
  input  logic                   capture_en,
  input  logic [DATA_W-1:0]      read_data,
  input  logic                   ack_in,
  output logic                   stall,
  output logic                   clk_out,
  output logic [OUT_W-1:0]       data_out,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int NCHUNK    = DATA_W / OUT_W;
  localparam int CW        = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int SMAX      = (STROBE_HI > STROBE_LO) ? STROBE_HI : STROBE_LO;
  localparam int SW        = (SMAX > 1) ? $clog2(SMAX) : 1;
  localparam int FIRST_POS = chunk_sel(NCHUNK, LSB_FIRST);

  tx_state_t         state, state_nx;
  logic [SW-1:0]     strobe_cnt, strobe_nx;
  logic [CW-1:0]     chunk_cnt, chunk_nx;
  logic [DATA_W-1:0] shreg, shreg_nx, shifted;
  logic [OUT_W-1:0]  dout_nx;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;
  logic              push_req, pop, next_chunk;

  assign push_req = com_en & capture_en;
  assign shifted  = LSB_FIRST ? (shreg >> OUT_W) : (shreg << OUT_W);
  assign stall    = fifo_full;
  assign clk_out  = (state == HIGH);
  assign busy     = (state != IDLE) | ~fifo_empty;

  interp_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .wdata (read_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_comb begin
    state_nx   = state;
    strobe_nx  = strobe_cnt;
    chunk_nx   = chunk_cnt;
    shreg_nx   = shreg;
    dout_nx    = data_out;
    pop        = 1'b0;
    next_chunk = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          shreg_nx = fifo_head;
          dout_nx  = fifo_head[FIRST_POS*OUT_W +: OUT_W];
          chunk_nx = CW'(NCHUNK - 1);
          state_nx = SETUP;
        end
      end
      SETUP: begin
        strobe_nx = '0;
        state_nx  = HIGH;
      end
      HIGH: begin
        if (strobe_cnt == SW'(STROBE_HI - 1)) begin
          strobe_nx = '0;
          state_nx  = LOW;
        end else begin
          strobe_nx = strobe_cnt + 1'b1;
        end
      end
      LOW: begin
        if (strobe_cnt == SW'(STROBE_LO - 1)) begin
          strobe_nx = '0;
`ifdef INTERP_TX_ACK_EN
          state_nx  = WAIT_ACK;
`else
          next_chunk = 1'b1;
`endif
        end else begin
          strobe_nx = strobe_cnt + 1'b1;
        end
      end
`ifdef INTERP_TX_ACK_EN
      WAIT_ACK: begin
        if (ack_in) begin
          next_chunk = 1'b1;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase

    // The last chunk leaves data_out untouched so it holds through IDLE.
    if (next_chunk) begin
      if (chunk_cnt != '0) begin
        chunk_nx = chunk_cnt - 1'b1;
        shreg_nx = shifted;
        dout_nx  = shifted[FIRST_POS*OUT_W +: OUT_W];
        state_nx = SETUP;
      end else begin
        state_nx = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      strobe_cnt <= '0;
      chunk_cnt  <= '0;
      shreg      <= '0;
      data_out   <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nx;
      strobe_cnt <= strobe_nx;
      chunk_cnt  <= chunk_nx;
      shreg      <= shreg_nx;
      data_out   <= dout_nx;
      if (push_req && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifndef INTERP_TX_ACK_EN
  logic unused_ack;
  assign unused_ack = ack_in;
`endif

endmodule

// File: tb/tb_interp_stream_tx.sv
// Directed self-checking bench for interp_stream_tx (LSB-first and MSB-first
// instances side by side); the ack-pacing step runs when INTERP_TX_ACK_EN is set.
module tb_interp_stream_tx;
  import interp_tx_pkg::*;

`ifdef INTERP_TX_ACK_EN
  localparam int ACK_CYC = 1;
`else
  localparam int ACK_CYC = 0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             com_en = 1'b0;
  logic             capture_en = 1'b0;
  logic [31:0]      read_data = '0;
  logic             ack_in = 1'b1;

  logic             stall, clk_out, busy, overflow;
  logic [7:0]       data_out;
  logic [LVL_W-1:0] level;
  logic             stall_m, clk_out_m, busy_m, overflow_m;
  logic [7:0]       data_out_m;
  logic [LVL_W-1:0] level_m;

  int checks = 0;
  int fails  = 0;

  logic [7:0]  chunks[$];
  logic        prev_clk_out = 1'b0;
  logic [31:0] words[10];
  logic [7:0]  lsb_seq[4];
  logic [7:0]  msb_seq[4];
  int          waited;

  interp_stream_tx #(.LSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .com_en(com_en), .capture_en(capture_en),
    .read_data(read_data), .ack_in(ack_in), .stall(stall), .clk_out(clk_out),
    .data_out(data_out), .busy(busy), .level(level), .overflow(overflow)
  );

  interp_stream_tx #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset(reset), .com_en(com_en), .capture_en(capture_en),
    .read_data(read_data), .ack_in(ack_in), .stall(stall_m), .clk_out(clk_out_m),
    .data_out(data_out_m), .busy(busy_m), .level(level_m), .overflow(overflow_m)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic ce, input logic cap, input logic [31:0] d);
    com_en     = ce;
    capture_en = cap;
    read_data  = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic sampleChunk();
    if (clk_out && !prev_clk_out) chunks.push_back(data_out);
    prev_clk_out = clk_out;
  endtask

  initial begin
    lsb_seq = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    msb_seq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 10; i++) words[i] = 32'h0A0B0C0D + 32'h11111111 * 32'(i);

    // Reset state
    tick(2);
    checkOutput("rst_clk_out", 32'(clk_out), 0);
    checkOutput("rst_data_out", 32'(data_out), 0);
    checkOutput("rst_stall", 32'(stall), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_level", 32'(level), 0);
    checkOutput("rst_overflow", 32'(overflow), 0);
    reset = 1'b0;
    tick(1);

    // Single word, both chunk orders
    $display("[TB] single word A1B2C3D4");
    applyStimulus(1'b1, 1'b1, 32'hA1B2C3D4);
    tick(1);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("push_level", 32'(level), 1);
    checkOutput("push_busy", 32'(busy), 1);
    tick(1);
    for (int k = 0; k < CHUNKS; k++) begin
      checkOutput($sformatf("lsb_chunk%0d", k), 32'(data_out), 32'(lsb_seq[k]));
      checkOutput($sformatf("msb_chunk%0d", k), 32'(data_out_m), 32'(msb_seq[k]));
      checkOutput($sformatf("setup_clk%0d", k), 32'(clk_out), 0);
      tick(1);
      checkOutput($sformatf("high1_clk%0d", k), 32'(clk_out), 1);
      tick(1);
      checkOutput($sformatf("high2_clk%0d", k), 32'(clk_out), 1);
      tick(1);
      checkOutput($sformatf("low1_clk%0d", k), 32'(clk_out), 0);
      tick(1);
      checkOutput($sformatf("low2_clk%0d", k), 32'(clk_out), 0);
      checkOutput($sformatf("low2_busy%0d", k), 32'(busy), 1);
      for (int a = 0; a < ACK_CYC; a++) begin
        tick(1);
        checkOutput($sformatf("ack_clk%0d", k), 32'(clk_out), 0);
      end
      tick(1);
    end
    checkOutput("done_busy", 32'(busy), 0);
    checkOutput("idle_hold_lsb", 32'(data_out), 32'hA1);
    checkOutput("idle_hold_msb", 32'(data_out_m), 32'hD4);

    // COM inactive: no captures
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, (i % 2) == 0, 32'hDEAD0000 + 32'(i));
      tick(1);
      checkOutput("nocom_level", 32'(level), 0);
      checkOutput("nocom_clk_out", 32'(clk_out), 0);
    end
    applyStimulus(1'b0, 1'b0, '0);

    // Ten back-to-back pushes: fill, stall, drop the tenth
    $display("[TB] burst of ten words");
    chunks.delete();
    prev_clk_out = clk_out;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, words[i]);
      tick(1);
      sampleChunk();
      checkOutput($sformatf("burst_level%0d", i), 32'(level),
                  (i == 0) ? 1 : ((i > 8) ? 8 : i));
      if (i == 8) checkOutput("burst_ovf_before", 32'(overflow), 0);
    end
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("burst_stall", 32'(stall), 1);
    checkOutput("burst_overflow", 32'(overflow), 1);
    waited = 0;
    while (chunks.size() < 36 && waited < 400) begin
      tick(1);
      sampleChunk();
      waited++;
    end
    checkOutput("burst_chunk_count", 32'(chunks.size()), 36);
    if (chunks.size() == 36) begin
      for (int w = 0; w < 9; w++)
        checkOutput($sformatf("burst_word%0d", w),
                    {chunks[4*w+3], chunks[4*w+2], chunks[4*w+1], chunks[4*w]},
                    words[w]);
    end
    waited = 0;
    while (busy && waited < 50) begin
      tick(1);
      waited++;
    end
    checkOutput("burst_drain_busy", 32'(busy), 0);
    checkOutput("burst_level_end", 32'(level), 0);
    checkOutput("burst_ovf_sticky", 32'(overflow), 1);

    // Reset during HIGH of chunk 2
    $display("[TB] reset mid-transfer");
    applyStimulus(1'b1, 1'b1, 32'hA1B2C3D4);
    tick(1);
    applyStimulus(1'b1, 1'b1, 32'h55667788);
    tick(1);
    applyStimulus(1'b0, 1'b0, '0);
    tick(6 + ACK_CYC);
    checkOutput("mid_clk_out", 32'(clk_out), 1);
    checkOutput("mid_data_out", 32'(data_out), 32'hC3);
    checkOutput("mid_level", 32'(level), 1);
    reset = 1'b1;
    tick(1);
    checkOutput("abort_clk_out", 32'(clk_out), 0);
    checkOutput("abort_data_out", 32'(data_out), 0);
    checkOutput("abort_level", 32'(level), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_overflow", 32'(overflow), 0);
    reset = 1'b0;
    tick(3);
    checkOutput("abort_idle_busy", 32'(busy), 0);
    checkOutput("abort_idle_clk", 32'(clk_out), 0);

`ifdef INTERP_TX_ACK_EN
    // Acknowledge pacing
    $display("[TB] ack pacing");
    ack_in = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'hA1B2C3D4);
    tick(1);
    applyStimulus(1'b0, 1'b0, '0);
    tick(1);
    checkOutput("ack_first_chunk", 32'(data_out), 32'hD4);
    tick(5);
    for (int i = 0; i < 10; i++) begin
      checkOutput("ack_wait_clk", 32'(clk_out), 0);
      checkOutput("ack_wait_data", 32'(data_out), 32'hD4);
      tick(1);
    end
    ack_in = 1'b1;
    tick(1);
    checkOutput("ack_next_data", 32'(data_out), 32'hC3);
    checkOutput("ack_next_setup", 32'(clk_out), 0);
    tick(1);
    checkOutput("ack_next_high", 32'(clk_out), 1);
    waited = 0;
    while (busy && waited < 100) begin
      tick(1);
      waited++;
    end
    checkOutput("ack_drain_busy", 32'(busy), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule

// File: doc/interp_stream_tx.md
# interp_stream_tx

Parametrised successor to the processor-to-interpreter output path. It captures load data read by the pipelined processor while the COM flag is active and buffers it in a FIFO. Each word is serialised into OUT_W-bit chunks, driven on `data_out` with a programmable-width `clk_out` strobe, and can optionally be paced by an acknowledge from the external interpreter. It sits in `top` between the CPU/RAM read-data bus and the interpreter pins, and feeds a stall back to the CPU when its buffer is full.

## Interface
Parameters:
- `DATA_W`, 32: captured word width; must be a multiple of OUT_W.
- `OUT_W`, 8: chunk width driven on `data_out`.
- `DEPTH`, 8: FIFO depth in words; power of two, at least 2.
- `STROBE_HI`, 2: cycles that `clk_out` is high per chunk; at least 1.
- `STROBE_LO`, 2: cycles that `clk_out` is low after the high phase; at least 1.
- `LSB_FIRST`, 1: 1 sends the least significant chunk first; 0 sends the most significant chunk first.

Ports:
- `clk` in 1: the single clock. Everything is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `com_en` in 1: COM flag from the CPU. Captures are enabled only while it is high.
- `capture_en` in 1: MemtoReg from the CPU. The word is captured when this and `com_en` are both high.
- `read_data` in DATA_W: the RAM q / ReadData bus.
- `ack_in` in 1: interpreter acknowledge. Used only when `INTERP_TX_ACK_EN` is defined.
- `stall` out 1: high when the FIFO is full.
- `clk_out` out 1: chunk strobe to the interpreter.
- `data_out` out OUT_W: current chunk.
- `busy` out 1: high when the FSM is not in IDLE or the FIFO is non-empty.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.
- `overflow` out 1: sticky flag for a dropped capture.

## Operation
- Push happens when `com_en & capture_en`. The push is accepted if `level < DEPTH`, or if a pop occurs in the same cycle. Otherwise the word is dropped and `overflow` is set to 1; it stays 1 until reset.
- `stall` is `level == DEPTH`, decoded from the registered count.
- FSM states: IDLE, SETUP, HIGH, LOW, and WAIT_ACK (WAIT_ACK exists only with the macro).
- IDLE: if the FIFO is non-empty, pop the head into the shift register, drive the first chunk on `data_out`, load the chunk counter with DATA_W/OUT_W-1, and go to SETUP.
- SETUP: hold for 1 cycle with `clk_out` = 0, then go to HIGH.
- HIGH: `clk_out` = 1 for STROBE_HI cycles, then go to LOW.
- LOW: `clk_out` = 0 for STROBE_LO cycles. Then go to WAIT_ACK if the macro is defined; otherwise go to the next-chunk decision.
- Next-chunk decision: if the chunk counter is non-zero, decrement it, shift, drive the next chunk, and go to SETUP. If it is zero, go to IDLE.
- `data_out` is stable from SETUP through the end of LOW/WAIT_ACK. In IDLE it holds the last chunk sent.
- Chunk order: with LSB_FIRST=1, send `[OUT_W-1:0]` first. With LSB_FIRST=0, send `[DATA_W-1:DATA_W-OUT_W]` first.

## Timing
- Reset values: `clk_out`=0, `data_out`=0, `stall`=0, `busy`=0, `level`=0, `overflow`=0. FSM is in IDLE and the FIFO is empty.
- Asserting reset mid-transfer aborts the transfer. All outputs reach their reset values at the next edge, and buffered words are discarded.
- Push at edge t: `level` increments at t. If the FSM is idle, the pop happens at t+1, and `data_out` is valid with the FSM in SETUP after edge t+1.
- Chunk period without ack: 1+STROBE_HI+STROBE_LO cycles.
- Word period: (DATA_W/OUT_W)×(1+STROBE_HI+STROBE_LO) cycles. Back-to-back words add 1 IDLE cycle.
- WAIT_ACK (macro only): `clk_out` = 0 and `data_out` is held until `ack_in` is sampled high. WAIT_ACK is left on the edge where `ack_in` is sampled high.
- A push and a pop in the same cycle leave `level` unchanged.

## Configuration
- `INTERP_TX_ACK_EN` defined: the WAIT_ACK state is compiled in, and each chunk stalls until `ack_in` is 1.
- `INTERP_TX_ACK_EN` undefined: pacing is purely timed and `ack_in` is ignored.

## Structure
- Package `interp_tx_pkg`:
  - the state enum `tx_state_t`;
  - localparams `CHUNKS = DATA_W/OUT_W`, `CNT_W`, `LVL_W`;
  - helper function `chunk_sel`.
- Sub-module `interp_fifo`: a synchronous FIFO with parametrised width and depth, exposing push/pop/full/empty/level. The wrapper holds the FSM, shift register, strobe counter and overflow logic.

## Test plan
1. Defaults: push 0xA1B2C3D4 once -> `data_out` D4, C3, B2, A1, each with 2 high cycles of `clk_out`. `busy` falls 21 cycles after the push (1 IDLE + 4×5).
2. LSB_FIRST=0, push 0xA1B2C3D4 -> chunk order A1, B2, C3, D4.
3. Push 10 consecutive words -> first word popped, 8 buffered, `stall`=1. 10th word dropped with `overflow`=1. The 9 accepted words are emitted in order.
4. `com_en`=0 with `capture_en` pulses -> `level` stays 0 and no `clk_out` activity.
5. Reset asserted during HIGH of chunk 2 -> next edge `clk_out`=0, `data_out`=0, `level`=0, state IDLE.
6. With `INTERP_TX_ACK_EN`, hold `ack_in`=0 for 10 cycles after the first LOW -> `clk_out` stays 0 and `data_out`=D4 is held. `ack_in`=1 -> SETUP of C3 on the next edge.
